alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the processor's combinational ALU. It executes the same 6-bit opcode set on WIDTH-bit operands through a start/done handshake. ADD, SUB and the logic/shift ops complete in one cycle; MUL, DIV and MOD run iteratively over WIDTH cycles. All outputs are registered and the full Z/N/C/V flag set is defined, plus a divide-by-zero flag. It sits between the control unit's execute state and the register file.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 75 +++++++
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ------------------------------------------------------------------
// alu_pkg : opcode encodings and FSM state type for alu_seq
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_MUL = 6'h02;
  localparam logic [5:0] OP_DIV = 6'h03;
  localparam logic [5:0] OP_MOD = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05;
  localparam logic [5:0] OP_OR  = 6'h06;
  localparam logic [5:0] OP_XOR = 6'h07;
  localparam logic [5:0] OP_NOT = 6'h08;
  localparam logic [5:0] OP_CMP = 6'h09;
  localparam logic [5:0] OP_MOV = 6'h0A;
  localparam logic [5:0] OP_RSR = 6'h0B;
  localparam logic [5:0] OP_RSL = 6'h0C;
  localparam logic [5:0] OP_LSR = 6'h0D;
  localparam logic [5:0] OP_LSL = 6'h0E;
  localparam logic [5:0] OP_TST = 6'h0F;
  localparam logic [5:0] OP_INC = 6'h10;
  localparam logic [5:0] OP_DEC = 6'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ------------------------------------------------------------------
// alu_muldiv_iter : one-bit-per-cycle shift-add multiplier / restoring divider
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic             run,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             last
);

  localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;
  logic [c_cnt_w-1:0] r_cnt;

  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;

  always_comb begin
    w_addend = r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}};
    w_sum    = {1'b0, r_hi} + w_addend;
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    // When w_ge holds the true difference is below r_b, so WIDTH bits suffice
    w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
    if (is_mul) begin
      next_hi = w_sum[WIDTH:1];
      next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      next_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
      next_lo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  assign last = run && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
      r_cnt <= '0;
    end else if (run) begin
      r_hi  <= next_hi;
      r_lo  <= next_lo;
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ------------------------------------------------------------------
// alu_seq : multi-cycle ALU with start/done handshake and registered flags
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] term1,
  input  logic [WIDTH-1:0] term2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             fl_zero,
  output logic             fl_negative,
  output logic             fl_carry,
  output logic             fl_overflow,
  output logic             fl_divz
);

  localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;

  logic             w_accept;
  logic             w_is_div;
  logic             w_divz;
  logic             w_needs_iter;

  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH-1:0] w_rot_amt;
  logic [WIDTH-1:0] w_rsr;
  logic [WIDTH-1:0] w_rsl;
  logic [WIDTH-1:0] w_lsr;
  logic [WIDTH-1:0] w_lsl;

  logic [WIDTH-1:0] w_sc_res;
  logic [WIDTH-1:0] w_sc_zn;
  logic             w_sc_c;
  logic             w_sc_v;

  logic             w_cap;
  logic [WIDTH-1:0] w_fin_res;
  logic [WIDTH-1:0] w_fin_zn;
  logic             w_fin_c;
  logic             w_fin_v;
  logic             w_fin_dz;

  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic             w_it_last;

  assign w_accept     = start && (r_state != ITER);
  assign w_is_div     = (opcode == OP_DIV) || (opcode == OP_MOD);
  assign w_divz       = w_is_div && (term2 == '0);
  assign w_needs_iter = (opcode == OP_MUL) || (w_is_div && !w_divz);

  assign busy = (r_state == ITER);
  assign done = (r_state == DONE);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_b   (rst_b),
    .load    (w_accept && w_needs_iter),
    .run     (r_state == ITER),
    .is_mul  (r_op == OP_MUL),
    .a       (term1),
    .b       (term2),
    .next_hi (w_it_hi),
    .next_lo (w_it_lo),
    .last    (w_it_last)
  );

  // Single-cycle datapath; INC/DEC reuse the adder with a constant operand
  always_comb begin
    w_opb     = ((opcode == OP_INC) || (opcode == OP_DEC)) ? c_one : term2;
    w_add     = {1'b0, term1} + {1'b0, w_opb};
    w_sub     = {1'b0, term1} - {1'b0, w_opb};
    w_add_v   = (term1[WIDTH-1] == w_opb[WIDTH-1]) && (w_add[WIDTH-1] != term1[WIDTH-1]);
    w_sub_v   = (term1[WIDTH-1] != w_opb[WIDTH-1]) && (w_sub[WIDTH-1] != term1[WIDTH-1]);
    w_rot_amt = term1 % c_width;
    w_rsr     = (term2 >> w_rot_amt) | (term2 << (c_width - w_rot_amt));
    w_rsl     = (term2 << w_rot_amt) | (term2 >> (c_width - w_rot_amt));
    w_lsr     = (term2 >= c_width) ? '0 : (term1 >> term2);
    w_lsl     = (term2 >= c_width) ? '0 : (term1 << term2);

    w_sc_res  = term1;
    w_sc_c    = 1'b0;
    w_sc_v    = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        w_sc_res = w_add[WIDTH-1:0];
        w_sc_c   = w_add[WIDTH];
        w_sc_v   = w_add_v;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        w_sc_res = (opcode == OP_CMP) ? term1 : w_sub[WIDTH-1:0];
        w_sc_c   = w_sub[WIDTH];
        w_sc_v   = w_sub_v;
      end
      OP_DIV:  w_sc_res = '1;
      OP_AND:  w_sc_res = term1 & term2;
      OP_OR:   w_sc_res = term1 | term2;
      OP_XOR:  w_sc_res = term1 ^ term2;
      OP_NOT:  w_sc_res = ~term1;
      OP_MOV:  w_sc_res = term2;
      OP_RSR:  w_sc_res = w_rsr;
      OP_RSL:  w_sc_res = w_rsl;
      OP_LSR:  w_sc_res = w_lsr;
      OP_LSL:  w_sc_res = w_lsl;
      OP_TST:  w_sc_res = {{(WIDTH-1){1'b0}}, w_lsr[0]};
      default: w_sc_res = term1;
    endcase
    // CMP keeps term1 as its result but reports Z/N of the difference
    w_sc_zn = (opcode == OP_CMP) ? w_sub[WIDTH-1:0] : w_sc_res;
  end

  always_comb begin
    w_cap     = 1'b0;
    w_fin_res = w_sc_res;
    w_fin_zn  = w_sc_zn;
    w_fin_c   = w_sc_c;
    w_fin_v   = w_sc_v;
    w_fin_dz  = 1'b0;
    if (w_accept && !w_needs_iter) begin
      w_cap    = 1'b1;
      w_fin_dz = w_divz;
    end else if (w_it_last) begin
      w_cap   = 1'b1;
      w_fin_c = 1'b0;
      w_fin_v = 1'b0;
      case (r_op)
        OP_MUL: begin
          w_fin_res = w_it_lo;
          w_fin_c   = |w_it_hi;
          w_fin_v   = |w_it_hi;
        end
        OP_DIV:  w_fin_res = w_it_lo;
        default: w_fin_res = w_it_hi;
      endcase
      w_fin_zn = w_fin_res;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_needs_iter ? ITER : DONE;
      ITER:    if (w_it_last) w_next = DONE;
      DONE:    w_next = start ? (w_needs_iter ? ITER : DONE) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_op        <= '0;
      result      <= '0;
      fl_zero     <= 1'b0;
      fl_negative <= 1'b0;
      fl_carry    <= 1'b0;
      fl_overflow <= 1'b0;
      fl_divz     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_op <= opcode;
      if (w_cap) begin
        result      <= w_fin_res;
        fl_zero     <= (w_fin_zn == '0);
        fl_negative <= w_fin_zn[WIDTH-1];
        fl_carry    <= w_fin_c;
        fl_overflow <= w_fin_v;
        fl_divz     <= w_fin_dz;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ------------------------------------------------------------------
// tb_alu_seq : directed and random checks of alu_seq against an arithmetic model
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [5:0]    opcode;
  logic [W-1:0]  term1;
  logic [W-1:0]  term2;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          fl_zero, fl_negative, fl_carry, fl_overflow, fl_divz;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .opcode      (opcode),
    .term1       (term1),
    .term2       (term2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .fl_zero     (fl_zero),
    .fl_negative (fl_negative),
    .fl_carry    (fl_carry),
    .fl_overflow (fl_overflow),
    .fl_divz     (fl_divz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference computed with wide integer arithmetic; flags packed {Z,N,C,V,DZ}
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [4:0] fl, output int lat);
    longint ua, ub, sa, sb, t, st, amt;
    logic [W-1:0] zn;
    logic c, v, dz;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 0; v = 0; dz = 0; lat = 1; r = a;
    if (op == 6'h10 || op == 6'h11) begin ub = 1; sb = 1; end
    case (op)
      6'h00, 6'h10: begin
        t = ua + ub; r = 16'(t); c = (t > 65535);
        st = sa + sb; v = (st > 32767) || (st < -32768);
      end
      6'h01, 6'h11, 6'h09: begin
        t = ua - ub; r = 16'(t); c = (ua < ub);
        st = sa - sb; v = (st > 32767) || (st < -32768);
      end
      6'h02: begin
        t = ua * ub; r = 16'(t); c = ((t >> 16) != 0); v = c; lat = W + 1;
      end
      6'h03, 6'h04: begin
        if (ub == 0) begin
          dz = 1; r = (op == 6'h03) ? 16'hFFFF : a;
        end else begin
          r = (op == 6'h03) ? 16'(ua / ub) : 16'(ua % ub); lat = W + 1;
        end
      end
      6'h05: r = a & b;
      6'h06: r = a | b;
      6'h07: r = a ^ b;
      6'h08: r = ~a;
      6'h0A: r = b;
      6'h0B: begin amt = ua % W; r = 16'((ub >> amt) | (ub << (W - amt))); end
      6'h0C: begin amt = ua % W; r = 16'((ub << amt) | (ub >> (W - amt))); end
      6'h0D: r = (ub >= W) ? 16'h0 : 16'(ua >> ub);
      6'h0E: r = (ub >= W) ? 16'h0 : 16'(ua << ub);
      6'h0F: r = (ub >= W) ? 16'h0 : 16'((ua >> ub) & 1);
      default: r = a;
    endcase
    zn = r;
    if (op == 6'h09) begin zn = 16'(ua - ub); r = a; end
    fl = {(zn == 0), zn[W-1], c, v, dz};
  endfunction

  // Called at a negedge; leaves the bench at the negedge of the done cycle (or one later with hold)
  task automatic run_op(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke, input bit hold);
    logic [W-1:0] er;
    logic [4:0]   ef;
    int           el, lat, bcnt;
    model(op, a, b, er, ef, el);
    start = 1'b1; opcode = op; term1 = a; term2 = b;
    @(negedge clk);
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == 2) begin term1 = ~a; term2 = 16'($urandom); opcode = 6'($urandom); end
      if (poke && lat == 5) start = 1'b1;
      if (poke && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " busy cycles"}, 32'(bcnt), 32'(el - 1));
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " flags"}, 32'({fl_zero, fl_negative, fl_carry, fl_overflow, fl_divz}), 32'(ef));
    if (hold) begin
      @(negedge clk);
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " result held"}, 32'(result), 32'(er));
    end
  endtask

  initial begin
    int dcount;
    logic [5:0] rop;
    logic [W-1:0] ra, rb;

    rst_b = 1'b0; start = 1'b0; opcode = '0; term1 = '0; term2 = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({busy, done, result, fl_zero, fl_negative, fl_carry, fl_overflow, fl_divz}), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    run_op("add_wrap", 6'h00, 16'hFFFF, 16'h0001, 0, 1);
    run_op("sub_ovf",  6'h01, 16'h8000, 16'h0001, 0, 1);
    run_op("cmp",      6'h09, 16'h0005, 16'h0007, 0, 0);
    run_op("mul",      6'h02, 16'd300,  16'd300,  1, 0);
    run_op("div",      6'h03, 16'd100,  16'd7,    0, 0);
    run_op("mod",      6'h04, 16'd100,  16'd7,    0, 1);
    run_op("div0",     6'h03, 16'd100,  16'd0,    0, 0);
    run_op("mod0",     6'h04, 16'd100,  16'd0,    0, 0);
    run_op("rsl",      6'h0C, 16'd1,    16'h8001, 0, 0);
    run_op("rsr",      6'h0B, 16'd17,   16'h0001, 0, 0);
    run_op("lsl16",    6'h0E, 16'h1234, 16'd16,   0, 1);
    run_op("inc_ovf",  6'h10, 16'h7FFF, 16'h0000, 0, 0);
    run_op("dec_zero", 6'h11, 16'h0000, 16'h0000, 0, 0);
    run_op("tst",      6'h0F, 16'h0008, 16'd3,    0, 1);

    // Reset in the middle of a multiply
    start = 1'b1; opcode = 6'h02; term1 = 16'd300; term2 = 16'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mul busy before reset", 32'(busy), 32'd1);
    #2 rst_b = 1'b0;
    #1 check("async reset outputs",
             32'({busy, done, result, fl_zero, fl_negative, fl_carry, fl_overflow, fl_divz}), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("no done after reset", 32'(dcount), 32'd0);
    run_op("add_after_reset", 6'h00, 16'h1234, 16'h4321, 0, 1);

    for (int i = 0; i < 40; i++) begin
      rop = 6'($urandom_range(0, 20));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run_op("random", rop, ra, rb, (i % 5) == 0, (i % 2) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
